// File: rtl/sync_tracker_pkg.sv
// Shared types and elaboration helpers for the symbol-sync tracker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: tracker state enum, period/counter-width helpers and the
// peak-offset saturation function used by the tracker datapath.
package sync_tracker_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        HOLD   = 2'd3
    } track_state_t;

    // Samples per symbol including the cyclic prefix.
    function automatic int period_of(input int sym_len, input int cp_len);
        return sym_len + cp_len;
    endfunction

    // Width of a counter that spans 0..period-1.
    function automatic int cnt_width(input int period);
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

    // Signed distance of a counter value from the predicted symbol start.
    // Values in the tail of the period are early (negative), the rest late.
    // The result is clamped to the range of a dly_w-bit signed number.
    function automatic int sat_offset(input int cnt, input int period,
                                      input int win, input int dly_w);
        int off;
        int lim_hi;
        int lim_lo;
        off    = (cnt >= period - win) ? cnt - period : cnt;
        lim_hi = (1 <<< (dly_w - 1)) - 1;
        lim_lo = -(1 <<< (dly_w - 1));
        if (off > lim_hi) begin
            off = lim_hi;
        end else if (off < lim_lo) begin
            off = lim_lo;
        end
        return off;
    endfunction

endpackage

// File: rtl/sym_phase_counter.sv
// Sample-phase flywheel: mod-PERIOD counter with load/hold/skip controls.
// Latency: count updates one clk after a qualifying ival; decodes are combinational.
// Backpressure: none; the counter only moves on ival, so gaps simply stall it.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   ival        sample strobe, enables every counter change
//   load        next value is 1 (the current sample is phase 0)
//   hold        repeat the current value once (slip late)
//   skip        advance by two (slip early)
//   cnt         current phase
//   in_window   cnt lies within +/-WIN of phase 0
//   at_close    cnt is the first phase after the window (not ival-qualified)
module sym_phase_counter #(
    parameter int PERIOD = 1056,
    parameter int CNT_W  = 11,
    parameter int WIN    = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ival,
    input  logic             load,
    input  logic             hold,
    input  logic             skip,
    output logic [CNT_W-1:0] cnt,
    output logic             in_window,
    output logic             at_close
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(PERIOD - 2);
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(PERIOD - WIN);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] CLOSE  = CNT_W'(WIN + 1);

    logic [CNT_W-1:0] cnt_d;
    // Set after a hold so the repeated close phase is not decoded twice.
    logic             held;
    logic             held_d;

    always_comb begin
        cnt_d  = cnt;
        held_d = held;
        if (ival) begin
            held_d = 1'b0;
            if (load) begin
                cnt_d = CNT_W'(1);
            end else if (hold) begin
                cnt_d  = cnt;
                held_d = 1'b1;
            end else if (skip) begin
                if (cnt == LAST) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt == PENULT) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(2);
                end
            end else begin
                cnt_d = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            held <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            held <= held_d;
        end
    end

    assign in_window = (cnt >= WIN_LO) || (cnt <= WIN_HI);
    assign at_close  = (cnt == CLOSE) && !held;

endmodule

// File: rtl/sync_tracker.sv
// Symbol-sync tracker: qualifies correlator peaks, runs a phase flywheel, regenerates SOP.
// Latency: every output is registered, one clk after the qualifying ival sample.
// Backpressure: none; ival gaps freeze all state, osop/lost_sync fall back to 0.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   ival, isop   sample strobe and correlator peak strobe (isop ignored without ival)
//   osop         regenerated symbol start, one cycle wide
//   delay_sop    signed offset of last accepted peak vs predicted start (+ = late)
//   found_sync   high in LOCKED or HOLD
//   lost_sync    one-cycle pulse when lock is dropped
//   state        0 SEARCH, 1 VERIFY, 2 LOCKED, 3 HOLD
//   hit_cnt      consecutive in-window peak count
// Build option: SYNC_TRACKER_PHASE_TRACK_EN lets the flywheel slip one sample
// per symbol toward the observed peak while LOCKED.
module sync_tracker
    import sync_tracker_pkg::*;
#(
    parameter int SYM_LEN  = 1024,
    parameter int CP_LEN   = 32,
    parameter int WIN      = 50,
    parameter int VERIFY_N = 3,
    parameter int MISS_MAX = 4,
    parameter int DLY_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ival,
    input  logic                    isop,
    output logic                    osop,
    output logic signed [DLY_W-1:0] delay_sop,
    output logic                    found_sync,
    output logic                    lost_sync,
    output logic [1:0]              state,
    output logic [2:0]              hit_cnt
);

    localparam int PERIOD = period_of(SYM_LEN, CP_LEN);
    localparam int CNT_W  = cnt_width(PERIOD);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [3:0]        VERIFY_LIM = 4'(VERIFY_N);
    localparam logic [2:0]        HITS_LOCK  = 3'(VERIFY_N);
    localparam logic [MISS_W:0]   MISS_LIM   = (MISS_W + 1)'(MISS_MAX);
`ifdef SYNC_TRACKER_PHASE_TRACK_EN
    localparam logic signed [DLY_W-1:0] SLIP_POS = DLY_W'(2);
    localparam logic signed [DLY_W-1:0] SLIP_NEG = DLY_W'(-2);
`endif

    track_state_t             state_q, state_d;
    logic [2:0]               hits_q, hits_d;
    logic [MISS_W-1:0]        miss_q, miss_d;
    // A peak has been accepted (or loaded) since the last window close.
    logic                     seen_q, seen_d;
    logic signed [DLY_W-1:0]  delay_q, delay_d;
    logic                     osop_q, osop_d;
    logic                     lost_q, lost_d;
    logic                     found_q, found_d;

    logic                     load;
    logic                     hold;
    logic                     skip;
    logic [CNT_W-1:0]         cnt;
    logic                     in_window;
    logic                     at_close;
    logic                     at_zero;

    int                       offset_full;
    logic signed [DLY_W-1:0]  offset;
    logic [3:0]               hits_inc;
    logic [MISS_W:0]          miss_inc;

    sym_phase_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W),
        .WIN    (WIN)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .ival      (ival),
        .load      (load),
        .hold      (hold),
        .skip      (skip),
        .cnt       (cnt),
        .in_window (in_window),
        .at_close  (at_close)
    );

    assign offset_full = sat_offset(int'(cnt), PERIOD, WIN, DLY_W);
    assign offset      = DLY_W'(offset_full);
    assign at_zero     = (cnt == '0);
    assign hits_inc    = {1'b0, hits_q} + 4'd1;
    assign miss_inc    = {1'b0, miss_q} + (MISS_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        seen_d  = seen_q;
        delay_d = delay_q;
        osop_d  = 1'b0;
        lost_d  = 1'b0;
        load    = 1'b0;
        hold    = 1'b0;
        skip    = 1'b0;
        if (ival) begin
            if (at_close) begin
                seen_d = 1'b0;
            end
            unique case (state_q)
                SEARCH: begin
                    if (isop) begin
                        load    = 1'b1;
                        seen_d  = 1'b1;
                        hits_d  = 3'd1;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (isop) begin
                        // Every peak re-anchors the phase; only in-window
                        // peaks extend the run of consecutive hits.
                        load   = 1'b1;
                        seen_d = 1'b1;
                        if (in_window) begin
                            delay_d = offset;
                            if (hits_inc >= VERIFY_LIM) begin
                                hits_d  = HITS_LOCK;
                                state_d = LOCKED;
                            end else begin
                                hits_d = hits_inc[2:0];
                            end
                        end else begin
                            hits_d = 3'd1;
                        end
                    end else if (at_close && !seen_q) begin
                        hits_d  = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    osop_d = at_zero;
                    if (isop && in_window) begin
                        delay_d = offset;
                        miss_d  = '0;
                        seen_d  = 1'b1;
                    end else if (at_close) begin
                        if (!seen_q) begin
                            miss_d  = MISS_W'(1);
                            state_d = HOLD;
                        end
`ifdef SYNC_TRACKER_PHASE_TRACK_EN
                        // Slip toward the peak seen in the window just closed.
                        else if (delay_q >= SLIP_POS) begin
                            hold = 1'b1;
                        end else if (delay_q <= SLIP_NEG) begin
                            skip = 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    osop_d = at_zero;
                    if (isop && in_window) begin
                        delay_d = offset;
                        miss_d  = '0;
                        seen_d  = 1'b1;
                        state_d = LOCKED;
                    end else if (at_close) begin
                        if (miss_inc >= MISS_LIM) begin
                            miss_d  = '0;
                            hits_d  = '0;
                            lost_d  = 1'b1;
                            state_d = SEARCH;
                        end else begin
                            miss_d = miss_inc[MISS_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        found_d = (state_d == LOCKED) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
            hits_q  <= '0;
            miss_q  <= '0;
            seen_q  <= 1'b0;
            delay_q <= '0;
            osop_q  <= 1'b0;
            lost_q  <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            seen_q  <= seen_d;
            delay_q <= delay_d;
            osop_q  <= osop_d;
            lost_q  <= lost_d;
            found_q <= found_d;
        end
    end

    assign osop       = osop_q;
    assign delay_sop  = delay_q;
    assign found_sync = found_q;
    assign lost_sync  = lost_q;
    assign state      = state_q;
    assign hit_cnt    = hits_q;

endmodule
